// File: rtl/draw_player_pkg.sv
// Shared VGA geometry, player sprite constants and the player motion state type.
package vgaPkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam int          PLAYER_W    = 32;
  localparam int          PLAYER_H    = 32;
  localparam logic [11:0] TRANSPARENT = 12'hF_0_F;
  localparam int          MOVE_STEP   = 2;
  localparam int          JUMP_STEP   = 4;
  localparam int          JUMP_TICKS  = 16;
  localparam int          X_START     = 32;
  localparam int          Y_FLOOR     = VER_PIXELS - 32 - PLAYER_H;

  // hcount + vcount + hsync + hblnk + vsync + vblnk + rgb
  localparam int STREAM_W = 38;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JUMP_UP = 2'd1,
    FALL    = 2'd2
  } player_state_e;
endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel colour stream passed between drawing stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_player_delay.sv
// Fixed-latency register chain with synchronous clear.
module delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [CLK_DEL-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign dout = r_pipe[CLK_DEL-1];
endmodule

// File: rtl/draw_player.sv
// Player sprite overlay on the VGA stream, with per-frame walk and jump motion.
module draw_player
  import vgaPkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump,
  input  logic [11:0] rgb_pixel,
  output logic [9:0]  pixel_addr,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        airborne,
  vga_if.in           in,
  vga_if.out          out
);
  player_state_e r_state;
  logic [3:0]    r_jump_cnt;
  logic [10:0]   r_pos_x, r_pos_y;
  logic          r_inside1, r_inside2;
  logic [9:0]    r_pixel_addr;

  logic          w_tick, w_inside, w_draw;
  logic [10:0]   w_dx, w_dy, w_x_next, w_y_up, w_y_fall;

  logic [STREAM_W-1:0] w_stream_in, w_stream_d2;
  logic [10:0]   w_hcount_d2, w_vcount_d2;
  logic          w_hsync_d2, w_hblnk_d2, w_vsync_d2, w_vblnk_d2;
  logic [11:0]   w_rgb_d2;

  assign w_tick = (in.hcount == 11'd0) && (in.vcount == 11'd0);

  // Offsets are only meaningful once hcount/vcount are known to be >= the corner.
  assign w_dx     = in.hcount - r_pos_x;
  assign w_dy     = in.vcount - r_pos_y;
  assign w_inside = start_game
                 && (in.hcount >= r_pos_x) && (w_dx < 11'(PLAYER_W))
                 && (in.vcount >= r_pos_y) && (w_dy < 11'(PLAYER_H));

  always_comb begin
    w_x_next = r_pos_x;
    if (move_left && !move_right)
      w_x_next = (r_pos_x >= 11'(MOVE_STEP)) ? r_pos_x - 11'(MOVE_STEP) : 11'd0;
    else if (move_right && !move_left)
      w_x_next = (r_pos_x >= 11'(HOR_PIXELS - PLAYER_W - MOVE_STEP)) ?
                 11'(HOR_PIXELS - PLAYER_W) : r_pos_x + 11'(MOVE_STEP);
  end

  assign w_y_up   = (r_pos_y >= 11'(JUMP_STEP)) ? r_pos_y - 11'(JUMP_STEP) : 11'd0;
  assign w_y_fall = (r_pos_y >= 11'(Y_FLOOR - JUMP_STEP)) ?
                    11'(Y_FLOOR) : r_pos_y + 11'(JUMP_STEP);

  // Motion only advances on the frame tick so a frame is never drawn half-moved.
  always_ff @(posedge clk) begin
    if (rst || !start_game) begin
      r_state    <= IDLE;
      r_jump_cnt <= '0;
      r_pos_x    <= 11'(X_START);
      r_pos_y    <= 11'(Y_FLOOR);
    end else if (w_tick) begin
      r_pos_x <= w_x_next;
      case (r_state)
        IDLE: begin
          if (jump) begin
            r_state    <= JUMP_UP;
            r_jump_cnt <= '0;
          end
        end
        JUMP_UP: begin
          r_pos_y    <= w_y_up;
          r_jump_cnt <= r_jump_cnt + 4'd1;
          if (r_jump_cnt == 4'(JUMP_TICKS - 1)) r_state <= FALL;
        end
        FALL: begin
          r_pos_y <= w_y_fall;
          if (w_y_fall == 11'(Y_FLOOR)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inside1    <= 1'b0;
      r_inside2    <= 1'b0;
      r_pixel_addr <= '0;
    end else begin
      r_inside1    <= w_inside;
      r_inside2    <= r_inside1;
      r_pixel_addr <= w_inside ? {w_dy[4:0], w_dx[4:0]} : 10'd0;
    end
  end

  assign w_stream_in = {in.hcount, in.vcount, in.hsync, in.hblnk, in.vsync, in.vblnk, in.rgb};

  delay #(
    .WIDTH   (STREAM_W),
    .CLK_DEL (2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (w_stream_in),
    .dout (w_stream_d2)
  );

  assign {w_hcount_d2, w_vcount_d2, w_hsync_d2, w_hblnk_d2,
          w_vsync_d2, w_vblnk_d2, w_rgb_d2} = w_stream_d2;

  // rgb_pixel lands here aligned with the twice-delayed stream.
  assign w_draw = r_inside2 && !(w_hblnk_d2 || w_vblnk_d2) && (rgb_pixel != TRANSPARENT);

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= w_hcount_d2;
      out.vcount <= w_vcount_d2;
      out.hsync  <= w_hsync_d2;
      out.hblnk  <= w_hblnk_d2;
      out.vsync  <= w_vsync_d2;
      out.vblnk  <= w_vblnk_d2;
      out.rgb    <= w_draw ? rgb_pixel : w_rgb_d2;
    end
  end

  assign pixel_addr = r_pixel_addr;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign airborne   = (r_state != IDLE);
endmodule

// File: doc/draw_player.md
DRAW_PLAYER -- requirements
Module: draw_player

Interface
REQ-001 Parameters, from vgaPkg, none local: PLAYER_W=32 (sprite width px); PLAYER_H=32 (sprite height px); TRANSPARENT=12'hF_0_F (key colour never drawn); MOVE_STEP=2 (px per frame horizontal); JUMP_STEP=4 (px per frame vertical); JUMP_TICKS=16 (frames of ascent); X_START=32 (reset x); Y_FLOOR=VER_PIXELS-32-PLAYER_H (resting y).
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 start_game  in  1  high = gameplay enabled.
REQ-005 move_left, move_right, jump  in  1 each  level inputs, already synchronised.
REQ-006 rgb_pixel  in  12  sprite ROM data, valid one cycle after pixel_addr.
REQ-007 pixel_addr  out  10  sprite ROM address {row[4:0], col[4:0]}.
REQ-008 pos_x, pos_y  out  11 each  current sprite top-left corner, for collision logic.
REQ-009 airborne  out  1  high when FSM is not IDLE.
REQ-010 in  vga_if.in  upstream timing/rgb stream (hcount, vcount, hsync, hblnk, vsync, vblnk, rgb), fed by the map stage.
REQ-011 out  vga_if.out  same stream with the sprite overlaid.

Function
REQ-012 Stream latency in->out SHALL be exactly 3 clk for every field; sync/blank/count fields SHALL be delayed unchanged.
REQ-013 Cycle 1: inside = (in.hcount in [pos_x, pos_x+PLAYER_W)) && (in.vcount in [pos_y, pos_y+PLAYER_H)) && start_game; pixel_addr registered as {5'(vcount-pos_y), 5'(hcount-pos_x)} when inside, else 0.
REQ-014 Cycle 3 output: out.rgb = rgb_pixel if inside (delayed 2) && !blank (delayed 2) && rgb_pixel != TRANSPARENT; otherwise the delayed in.rgb.
REQ-015 Frame tick SHALL be one clk pulse when in.hcount==0 && in.vcount==0; pos_x, pos_y and FSM SHALL change only on tick (no mid-frame tearing).
REQ-016 Horizontal on tick: left only -> pos_x -= MOVE_STEP, floored at 0; right only -> pos_x += MOVE_STEP, capped at HOR_PIXELS-PLAYER_W; both or neither -> unchanged.
REQ-017 FSM states IDLE, JUMP_UP, FALL; transitions evaluated on tick only.
REQ-018 IDLE: jump=1 -> JUMP_UP, jump_cnt=0, pos_y unchanged this tick.
REQ-019 JUMP_UP: pos_y -= JUMP_STEP, jump_cnt++; when jump_cnt==JUMP_TICKS-1 (after the decrement) -> FALL; jump input ignored.
REQ-020 FALL: pos_y += JUMP_STEP, saturating at Y_FLOOR; tick on which pos_y reaches Y_FLOOR -> IDLE; jump ignored.
REQ-021 Horizontal motion SHALL apply in all states, including the same tick as a jump start.
REQ-022 start_game=0: FSM forced IDLE, pos_x=X_START, pos_y=Y_FLOOR, no sprite drawn (pure 3-cycle passthrough).
REQ-023 Counter widths: jump_cnt 4 bits; position arithmetic in 11 bits with clamp evaluated before wrap can occur.

Reset
REQ-024 On rst: all out.* fields 0, pixel_addr 0, pos_x=X_START, pos_y=Y_FLOOR, airborne 0, FSM IDLE, jump_cnt 0, delay pipeline cleared.
REQ-025 Reset mid-jump SHALL return to IDLE at Y_FLOOR on the next clk with no residual motion.

Structure
REQ-026 All REQ-001 constants and the FSM state enum typedef SHALL live in vgaPkg.
REQ-027 The existing delay sub-module SHALL be instantiated for the stream fields (WIDTH=38, CLK_DEL=2) plus the final output register; no other sub-module.

Verification (bench: HOR_PIXELS=1024, VER_PIXELS=768, so Y_FLOOR=704)
REQ-028 Reset, start_game=1, sprite ROM model with all pixels 12'h0_F_0 -> out.rgb=12'h0_F_0 exactly for hcount 32..63, vcount 704..735, 3 clk after input; in.rgb elsewhere.
REQ-029 ROM pixel (row 0, col 0)=TRANSPARENT, in.rgb=12'h1_2_3 -> out.rgb=12'h1_2_3 at (32,704).
REQ-030 move_left held 20 frames from X_START -> pos_x 30,28,...,0 after 16 ticks, then stays 0; both left+right -> pos_x unchanged.
REQ-031 Single-tick jump pulse -> pos_y 704,700,...,640 over 16 ticks, airborne=1, then 644..704 over 16 ticks, IDLE; jump held throughout gives no re-trigger until IDLE.
REQ-032 rst asserted at tick 5 of JUMP_UP -> next clk pos_y=704, airborne=0, out.* all 0.
REQ-033 start_game=0 with move_right held -> pos_x stays 32, out stream equals in stream delayed 3 clk bit-exact.
